// File: rtl/stack_alu_seq.sv
// Clocked stack-machine ALU: a DEPTH-entry LIFO of signed words with one-cycle
// stack/ADD/SUB ops and an iterative shift-add MUL taking WIDTH+1 cycles.
module stack_alu_seq #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [2:0]                   opcode,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         out_valid,
  output logic [WIDTH-1:0]             out_data,
  output logic                         overflow,
  output logic                         err,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam int IW = $clog2(WIDTH);

  localparam logic [2:0] OP_DUP  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_PUSH = 3'b110;
  localparam logic [2:0] OP_POP  = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_MBUSY, S_MDONE} state_t;

  state_t               r_state, w_nextState;
  logic [WIDTH-1:0]     r_mem [DEPTH];
  logic [CW-1:0]        r_count;
  logic                 r_outValid, r_overflow, r_err, r_neg;
  logic [WIDTH-1:0]     r_outData;
  logic [IW-1:0]        r_iter;
  logic [2*WIDTH-1:0]   r_mcand, r_acc;
  logic [WIDTH:0]       r_mplier;

  logic                 w_accept, w_empty, w_full, w_lt2;
  logic [AW-1:0]        w_topIdx, w_nxtIdx, w_pushIdx;
  logic [WIDTH-1:0]     w_top, w_nxt, w_sum, w_diff, w_prodLow;
  logic                 w_addOvf, w_subOvf, w_mulOvf;
  logic [WIDTH:0]       w_nExt, w_tExt, w_absN, w_absT;
  logic [2*WIDTH-1:0]   w_prod;

  logic                 w_we, w_report, w_repErr, w_repOvf, w_startMul;
  logic [AW-1:0]        w_waddr;
  logic [WIDTH-1:0]     w_wdata, w_repData;
  logic [CW-1:0]        w_countNext;

  assign w_accept  = in_valid && in_ready;
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CW'(DEPTH));
  assign w_lt2     = (r_count < CW'(2));
  assign w_topIdx  = AW'(r_count - CW'(1));
  assign w_nxtIdx  = AW'(r_count - CW'(2));
  assign w_pushIdx = AW'(r_count);
  assign w_top     = r_mem[w_topIdx];
  assign w_nxt     = r_mem[w_nxtIdx];

  assign w_sum    = w_nxt + w_top;
  assign w_diff   = w_nxt - w_top;
  assign w_addOvf = (w_nxt[WIDTH-1] == w_top[WIDTH-1]) && (w_sum[WIDTH-1] != w_nxt[WIDTH-1]);
  assign w_subOvf = (w_nxt[WIDTH-1] != w_top[WIDTH-1]) && (w_diff[WIDTH-1] != w_nxt[WIDTH-1]);

  // Magnitudes carry one extra bit so the most negative word negates cleanly
  assign w_nExt = {w_nxt[WIDTH-1], w_nxt};
  assign w_tExt = {w_top[WIDTH-1], w_top};
  assign w_absN = w_nxt[WIDTH-1] ? -w_nExt : w_nExt;
  assign w_absT = w_top[WIDTH-1] ? -w_tExt : w_tExt;

  assign w_prod    = r_neg ? -r_acc : r_acc;
  assign w_prodLow = w_prod[WIDTH-1:0];
  assign w_mulOvf  = (w_prod[2*WIDTH-1:WIDTH] != {WIDTH{w_prod[WIDTH-1]}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:  if (w_startMul) w_nextState = S_MBUSY;
      S_MBUSY: if (r_iter == '0) w_nextState = S_MDONE;
      S_MDONE: w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (r_state == S_IDLE);
  end

  // Per-cycle decode: stack write, count update and the report to register
  always_comb begin
    w_we        = 1'b0;
    w_waddr     = w_pushIdx;
    w_wdata     = in_data;
    w_report    = 1'b0;
    w_repErr    = 1'b0;
    w_repData   = '0;
    w_repOvf    = 1'b0;
    w_countNext = r_count;
    w_startMul  = 1'b0;
    if (r_state == S_IDLE && w_accept) begin
      case (opcode)
        OP_PUSH: begin
          if (w_full) begin
            w_report = 1'b1;
            w_repErr = 1'b1;
          end else begin
            w_we        = 1'b1;
            w_countNext = r_count + CW'(1);
          end
        end
        OP_POP: begin
          w_report = 1'b1;
          if (w_empty) w_repErr = 1'b1;
          else begin
            w_repData   = w_top;
            w_countNext = r_count - CW'(1);
          end
        end
        OP_DUP: begin
          if (w_empty || w_full) begin
            w_report = 1'b1;
            w_repErr = 1'b1;
          end else begin
            w_we        = 1'b1;
            w_wdata     = w_top;
            w_countNext = r_count + CW'(1);
          end
        end
        OP_ADD, OP_SUB: begin
          w_report = 1'b1;
          if (w_lt2) w_repErr = 1'b1;
          else begin
            w_we        = 1'b1;
            w_waddr     = w_nxtIdx;
            w_wdata     = (opcode == OP_ADD) ? w_sum : w_diff;
            w_repData   = w_wdata;
            w_repOvf    = (opcode == OP_ADD) ? w_addOvf : w_subOvf;
            w_countNext = r_count - CW'(1);
          end
        end
        OP_MUL: begin
          if (w_lt2) begin
            w_report = 1'b1;
            w_repErr = 1'b1;
          end else begin
            w_startMul = 1'b1;
          end
        end
        default: ;
      endcase
    end else if (r_state == S_MDONE) begin
      w_we        = 1'b1;
      w_waddr     = w_nxtIdx;
      w_wdata     = w_prodLow;
      w_report    = 1'b1;
      w_repData   = w_prodLow;
      w_repOvf    = w_mulOvf;
      w_countNext = r_count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
  end

  // Unsigned shift-add on magnitudes; the sign is reapplied when the result is written
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_iter   <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_neg    <= 1'b0;
    end else if (w_startMul) begin
      r_iter   <= IW'(WIDTH - 1);
      r_mcand  <= {{(WIDTH-1){1'b0}}, w_absN};
      r_mplier <= w_absT;
      r_acc    <= '0;
      r_neg    <= w_nxt[WIDTH-1] ^ w_top[WIDTH-1];
    end else if (r_state == S_MBUSY) begin
      if (r_mplier[0]) r_acc <= r_acc + r_mcand;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_iter   <= r_iter - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count    <= '0;
      r_outValid <= 1'b0;
      r_outData  <= '0;
      r_overflow <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_count    <= w_countNext;
      r_outValid <= w_report;
      if (w_report) begin
        r_outData  <= w_repData;
        r_overflow <= w_repOvf;
        r_err      <= w_repErr;
      end
    end
  end

  assign out_valid = r_outValid;
  assign out_data  = r_outData;
  assign overflow  = r_overflow;
  assign err       = r_err;
  assign count     = r_count;

endmodule

// File: doc/stack_alu_seq.md
# stack_alu_seq

Clocked, parametrised stack-machine ALU, successor to the combinational stack ALU. It holds a LIFO of DEPTH signed WIDTH-bit words and accepts one opcode per handshake. Arithmetic ops consume the top two entries and push the result; PUSH, POP and DUP manage the stack. MUL runs as an iterative multi-cycle operation, and underflow/full errors are reported explicitly.

## Interface
- WIDTH, 8, data word width in bits, two's complement, ≥ 2
- DEPTH, 8, stack entries, ≥ 2
- clk  input  1  single clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- in_valid  input  1  opcode/in_data valid
- in_ready  output  1  block can accept an op this cycle
- opcode  input  3  000 NOP, 001 DUP, 010 SUB, 011 reserved (NOP), 100 ADD, 101 MUL, 110 PUSH, 111 POP
- in_data  input  WIDTH  operand for PUSH, ignored otherwise
- out_valid  output  1  one-cycle pulse: out_data/overflow/err valid
- out_data  output  WIDTH  popped value or arithmetic result
- overflow  output  1  signed overflow of the reported result, qualified by out_valid
- err  output  1  stack underflow or full, qualified by out_valid
- count  output  $clog2(DEPTH+1)  current number of stack entries

## Operation
- Accept when in_valid && in_ready at a rising edge. There is no output backpressure.
- Let T be the top entry and N the entry below it.
- PUSH: writes in_data and increments count. No out_valid.
- POP: out_data = T, decrements count.
- DUP: pushes a copy of T. No out_valid on success.
- ADD: pops T and N, pushes N+T, and reports it on out_data. Net count −1.
- SUB: pops T and N, pushes N−T, and reports it on out_data. Net count −1.
- MUL: pops T and N, pushes the low WIDTH bits of N×T (signed), and reports it on out_data. Net count −1.
- NOP/reserved: accepted, no effect, no out_valid.
- Overflow rules:
  - ADD sets overflow when the operand signs match and the result sign differs.
  - SUB sets overflow when the operand signs differ and the result sign differs from N.
  - MUL sets overflow when the full 2·WIDTH product is not the sign-extension of its low WIDTH bits.
  - POP, and any op with err=1, drive overflow=0.
- Error cases: POP with count=0, DUP with count=0 or count=DEPTH, ADD/SUB/MUL with count<2, PUSH with count=DEPTH.
  - The stack is left unchanged.
  - out_valid=1, err=1, out_data=0, overflow=0.
- Error-free ops that produce output drive err=0.
- MUL datapath:
  - Latch |N|, |T| and the XOR of their signs.
  - Shift-add one bit per cycle for WIDTH cycles into a 2·WIDTH accumulator.
  - Negate the accumulator if the signs differ.
  - The most negative operand is handled via WIDTH+1-bit magnitude.
- FSM states:
  - IDLE (in_ready=1): non-MUL ops complete here; a valid MUL goes to MBUSY; a MUL that errors stays in IDLE.
  - MBUSY (in_ready=0): iteration counter runs WIDTH−1 down to 0; at 0 go to MDONE.
  - MDONE (in_ready=0): write the result to the stack, pulse out_valid, return to IDLE.

## Timing
- Reset values: out_valid=0, out_data=0, overflow=0, err=0, count=0, in_ready=1, state IDLE. Stack RAM contents are not reset.
- PUSH/POP/DUP/ADD/SUB and all error responses: accepted at edge k, outputs and count valid after edge k.
  - Latency is 1 cycle, at full throughput of one op per cycle.
- MUL accepted at edge k:
  - in_ready is low after edge k.
  - out_valid pulses and count updates after edge k+WIDTH+1.
  - in_ready is high again after edge k+WIDTH+1.
  - Throughput is one MUL per WIDTH+1 cycles.
- out_valid is high for exactly one cycle per reporting op; out_data holds its value until the next report.
- Ops presented while in_ready=0 are not accepted; the source must hold them.
- Reset asserted mid-MUL aborts immediately: count=0, state IDLE, no out_valid.
- count never exceeds DEPTH or goes below 0.

## Test plan
- WIDTH=8, DEPTH=4: PUSH 5, PUSH 3, ADD → out_data=8, overflow=0, count=1; POP → out_data=8, count=0.
- PUSH 100, PUSH 100, ADD → out_data=0xC8 (−56), overflow=1. PUSH 0x80, PUSH 1, SUB → out_data=0x7F, overflow=1.
- PUSH −3 (0xFD), PUSH 7, MUL → in_ready low for 9 cycles, out_data=0xEB (−21), overflow=0, out_valid 9 cycles after acceptance. PUSH 16, PUSH 16, MUL → out_data=0x00, overflow=1.
- Boundaries: POP on empty → err=1, out_data=0, count=0. PUSH 4×, then PUSH again → err=1, count=4. DUP at count=4 → err=1. ADD with count=1 → err=1, count stays 1.
- Back-to-back PUSH/DUP/SUB on consecutive cycles with in_valid held high → one op per cycle, DUP+SUB of x yields out_data=0. An op held while MUL is busy is accepted only after in_ready rises.
- Assert rst_n low during MBUSY → all outputs at reset values asynchronously. After release, POP → err=1.
